triang_inv_mat_server: RTL

Synthesizable matrix buffer on the memory side of `traing_matrix_inv`. It stores the SIZE×SIZE complex upper-triangular input matrix loaded by a host, answers the inverter's row-fetch requests, and captures the inverse columns the inverter emits. It then lets the host read the inverse back by column address. It replaces the behavioural row memory and column store that surround the inverter in simulation.

---
 rtl/triang_inv_mat_server.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/triang_inv_mat_server.sv
// Matrix buffer for the triangular inverter: holds the loaded upper-triangular
// matrix, serves row fetches, captures inverse columns and returns them to the host.
module triang_inv_mat_server #(
    parameter int SIZE       = 16,
    parameter int WIDTH      = 64,
    parameter int ZERO_LOWER = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic [SIZE*2*WIDTH-1:0]         host_row_i,
    input  logic                            host_row_valid_i,
    output logic                            host_row_ready_o,
    input  logic                            host_col_rd_i,
    input  logic [$clog2(SIZE)-1:0]         host_col_addr_i,
    output logic [SIZE*2*WIDTH-1:0]         host_col_o,
    output logic                            host_col_valid_o,
    output logic                            inv_start_o,
    input  logic [$clog2(SIZE)-1:0]         req_addr_i,
    input  logic                            req_valid_i,
    output logic [SIZE*2*WIDTH-1:0]         row_o,
    output logic [$clog2(SIZE)-1:0]         row_addr_o,
    output logic                            row_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]         col_i,
    input  logic [$clog2(SIZE)-1:0]         col_addr_i,
    input  logic                            col_valid_i,
    output logic                            out_ready_o,
    output logic                            done_o
);
    localparam int AW = $clog2(SIZE);
    localparam int EW = 2 * WIDTH;
    localparam int RW = SIZE * EW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_r, state_s;
    logic [AW-1:0]     load_cnt_r, load_cnt_s;
    logic [SIZE-1:0]   col_mask_r, col_mask_s;
    logic              done_r, done_s;
    logic              row_accept_s, col_write_s, req_take_s, host_rd_s;
    logic              ready_r, inv_start_r, out_ready_r;
    logic [RW-1:0]     row_r, host_col_r;
    logic [AW-1:0]     row_addr_r;
    logic              row_valid_r, host_col_valid_r;
    logic [RW-1:0]     row_mem [SIZE];
    logic [RW-1:0]     col_mem [SIZE];

    // Row i keeps only its upper-triangular part when ZERO_LOWER is set.
    function automatic logic [RW-1:0] mask_lower(input logic [RW-1:0] row,
                                                 input logic [AW-1:0] idx);
        logic [RW-1:0] res;
        res = row;
        for (int j = 0; j < SIZE; j++) begin
            if ((ZERO_LOWER != 0) && (j < int'(idx))) begin
                res[j*EW +: EW] = {EW{1'b0}};
            end else begin
                res[j*EW +: EW] = row[j*EW +: EW];
            end
        end
        return res;
    endfunction

    assign req_take_s = (state_r == S_RUN) && req_valid_i && !flush_i;
    assign host_rd_s  = (state_r == S_DONE) && host_col_rd_i && !flush_i;

    // Next-state, load counter, column mask and done flag.
    always_comb begin
        state_s      = state_r;
        load_cnt_s   = load_cnt_r;
        col_mask_s   = col_mask_r;
        done_s       = done_r;
        row_accept_s = 1'b0;
        col_write_s  = 1'b0;
        if (flush_i) begin
            state_s    = S_IDLE;
            load_cnt_s = {AW{1'b0}};
            col_mask_s = {SIZE{1'b0}};
            done_s     = 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_LOAD, S_DONE: begin
                    if (host_row_valid_i) begin
                        row_accept_s = 1'b1;
                        if (state_r != S_LOAD) begin
                            col_mask_s = {SIZE{1'b0}};
                            done_s     = 1'b0;
                        end else begin
                            col_mask_s = col_mask_r;
                        end
                        if (load_cnt_r == AW'(SIZE - 1)) begin
                            load_cnt_s = {AW{1'b0}};
                            state_s    = S_START;
                        end else begin
                            load_cnt_s = load_cnt_r + AW'(1'b1);
                            state_s    = S_LOAD;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                S_START: state_s = S_RUN;
                S_RUN: begin
                    if (col_valid_i) begin
                        col_write_s = 1'b1;
                        col_mask_s  = col_mask_r | ({{(SIZE-1){1'b0}}, 1'b1} << col_addr_i);
                        if (&col_mask_s) begin
                            state_s = S_DONE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = S_RUN;
                        end
                    end else begin
                        state_s = S_RUN;
                    end
                end
                default: state_s = S_IDLE;
            endcase
        end
    end

    // Control state and registered outputs; memories are deliberately not reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r          <= S_IDLE;
            load_cnt_r       <= {AW{1'b0}};
            col_mask_r       <= {SIZE{1'b0}};
            done_r           <= 1'b0;
            ready_r          <= 1'b1;
            inv_start_r      <= 1'b0;
            out_ready_r      <= 1'b0;
            row_r            <= {RW{1'b0}};
            row_addr_r       <= {AW{1'b0}};
            row_valid_r      <= 1'b0;
            host_col_r       <= {RW{1'b0}};
            host_col_valid_r <= 1'b0;
        end else begin
            state_r          <= state_s;
            load_cnt_r       <= load_cnt_s;
            col_mask_r       <= col_mask_s;
            done_r           <= done_s;
            ready_r          <= (state_s == S_IDLE) || (state_s == S_LOAD) || (state_s == S_DONE);
            inv_start_r      <= (state_s == S_START);
            out_ready_r      <= (state_s == S_RUN);
            row_valid_r      <= req_take_s;
            host_col_valid_r <= host_rd_s;
            if (req_take_s) begin
                row_r      <= row_mem[req_addr_i];
                row_addr_r <= req_addr_i;
            end else begin
                row_r      <= row_r;
                row_addr_r <= row_addr_r;
            end
            if (host_rd_s) begin
                host_col_r <= col_mem[host_col_addr_i];
            end else begin
                host_col_r <= host_col_r;
            end
        end
    end

    // Row and column storage.
    always_ff @(posedge clk_i) begin
        if (row_accept_s) begin
            row_mem[load_cnt_r] <= mask_lower(host_row_i, load_cnt_r);
        end
        if (col_write_s) begin
            col_mem[col_addr_i] <= col_i;
        end
    end

    assign host_row_ready_o = ready_r;
    assign inv_start_o      = inv_start_r;
    assign out_ready_o      = out_ready_r;
    assign done_o           = done_r;
    assign row_o            = row_r;
    assign row_addr_o       = row_addr_r;
    assign row_valid_o      = row_valid_r;
    assign host_col_o       = host_col_r;
    assign host_col_valid_o = host_col_valid_r;

endmodule
